// File: rtl/ram_dp_responder_pkg.sv
// Shared types and default geometry for the dual-port RAM responder and its interface.
package ram_pkg;

  localparam int RAM_ADDR_WIDTH = 4;
  localparam int RAM_DATA_WIDTH = 8;

  typedef enum logic {INIT, RUN} ram_state_e;

  typedef logic [RAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [RAM_DATA_WIDTH-1:0] data_t;

endpackage : ram_pkg

// File: rtl/ram_dp_responder_if.sv
// RAM write/read request bus between a driver (master) and the RAM responder (slave).
interface ram_dp_responder_if
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  init_done;
  logic                  req_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_done, req_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_done, req_drop
  );

endinterface : ram_dp_responder_if

// File: rtl/ram_dp_responder_init_seq.sv
// Post-reset init sweep: walks every address once, then parks in RUN until the next reset.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_wr_en,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  init_done
);

  localparam int                CNT_W = ADDR_WIDTH + 1;
  localparam int                DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DEPTH - 1);

  ram_state_e       state;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  assign init_wr_en = (state == INIT) && !rst;
  assign init_addr  = cnt[ADDR_WIDTH-1:0];

endmodule : ram_init_seq

// File: rtl/ram_dp_responder.sv
// Simple dual-port synchronous RAM with one-cycle registered read, collision policy and
// a self-clearing init sweep after every reset.
module ram_dp_responder
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = RAM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = RAM_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0,
  parameter bit                    WRITE_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  ram_dp_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                  init_wr_en;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_done;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  req_drop_q;
  logic                  collide;

  ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .init_wr_en (init_wr_en),
    .init_addr  (init_addr),
    .init_done  (init_done)
  );

  // NOTE: the array has no reset branch on purpose; the init sweep clears it, which keeps it mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (init_wr_en) begin
      mem[init_addr] <= INIT_VALUE;
    end else if (init_done && bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign collide = WRITE_FIRST && bus.wr_en && (bus.wr_addr == bus.rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      req_drop_q <= !init_done && (bus.wr_en || bus.rd_en);
      rd_valid_q <= init_done && bus.rd_en;
      if (init_done && bus.rd_en) begin
        rd_data_q <= collide ? bus.wr_data : mem[bus.rd_addr];
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.init_done = init_done;
  assign bus.req_drop  = req_drop_q;

  // Request strobes must be known whenever the port is live.
  a_req_known : assert property (@(posedge clk) disable iff (rst)
    init_done |-> !$isunknown({bus.wr_en, bus.rd_en}));

endmodule : ram_dp_responder
